// File: rtl/dtim_arb_pkg.sv
// Shared types for the DTIM port arbiter.
//   owner_e    : which requester issued an in-flight access
//   inflight_t : one owner-pipeline entry {valid, owner, is_write}
package dtim_arb_pkg;

    typedef enum logic {
        OWNER_CORE,
        OWNER_DMA
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_write;
    } inflight_t;

endpackage

// File: rtl/dtim_arb_resp_pipe.sv
// Owner pipeline: a DEPTH-stage shift register of in-flight access records, so each
// response can be routed to its issuer exactly DEPTH cycles after the access was granted.
// Ports:
//   clock   : sole clock
//   reset   : synchronous, active-high; clears every stage (drops in-flight accesses)
//   entry_i : record for the access granted this cycle (valid = 0 when idle)
//   entry_o : record leaving the pipeline this cycle
module dtim_arb_resp_pipe
    import dtim_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clock,
    input  logic      reset,
    input  inflight_t entry_i,
    output inflight_t entry_o
);

    inflight_t stage_q [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= entry_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign entry_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dtim_port_arbiter.sv
// Shares the single-port DTIM RAM between the core data port (primary) and the debug/DMA
// loader port (secondary). One access per cycle; request handshake is combinational and
// responses come back MEM_LATENCY cycles after acceptance on the issuer's response port.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   core_req_* / dma_req_*    : valid/ready request with write, addr, wdata, wmask
//   core_resp_* / dma_resp_*  : one-cycle response pulse; rdata is 0 for write acks
//   mem_en/we/addr/wdata      : RAM port driven by the granted requester
//   mem_rdata                 : RAM read data, valid MEM_LATENCY cycles after mem_en
module dtim_port_arbiter
    import dtim_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    core_req_valid,
    output logic                    core_req_ready,
    input  logic                    core_req_write,
    input  logic [ADDR_WIDTH-1:0]   core_req_addr,
    input  logic [DATA_WIDTH-1:0]   core_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] core_req_wmask,
    output logic                    core_resp_valid,
    output logic [DATA_WIDTH-1:0]   core_resp_rdata,

    input  logic                    dma_req_valid,
    output logic                    dma_req_ready,
    input  logic                    dma_req_write,
    input  logic [ADDR_WIDTH-1:0]   dma_req_addr,
    input  logic [DATA_WIDTH-1:0]   dma_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] dma_req_wmask,
    output logic                    dma_resp_valid,
    output logic [DATA_WIDTH-1:0]   dma_resp_rdata,

    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] starve_q, starve_d;
    logic                 grant_core, grant_dma;
    logic                 sel_write;
    inflight_t            push_entry, head_entry;

    // DMA wins when alone, or when it has been denied STARVE_LIMIT cycles in a row.
    // Grants are masked during reset so nothing is accepted or driven to the RAM.
    assign grant_dma  = ~reset & dma_req_valid & (~core_req_valid | (starve_q == LIMIT));
    assign grant_core = ~reset & core_req_valid & ~grant_dma;

    assign core_req_ready = grant_core;
    assign dma_req_ready  = grant_dma;

    always_comb begin
        mem_en    = grant_core | grant_dma;
        sel_write = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_dma) begin
            sel_write = dma_req_write;
            mem_we    = dma_req_wmask & {MASK_WIDTH{dma_req_write}};
            mem_addr  = dma_req_addr;
            mem_wdata = dma_req_wdata;
        end else if (grant_core) begin
            sel_write = core_req_write;
            mem_we    = core_req_wmask & {MASK_WIDTH{core_req_write}};
            mem_addr  = core_req_addr;
            mem_wdata = core_req_wdata;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!dma_req_valid || grant_dma) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_comb begin
        push_entry.valid    = mem_en;
        push_entry.owner    = grant_dma ? OWNER_DMA : OWNER_CORE;
        push_entry.is_write = sel_write;
    end

    dtim_arb_resp_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_resp_pipe (
        .clock   (clock),
        .reset   (reset),
        .entry_i (push_entry),
        .entry_o (head_entry)
    );

    // The head entry is suppressed during reset so an access already in flight is dropped.
    always_comb begin
        core_resp_valid = ~reset & head_entry.valid & (head_entry.owner == OWNER_CORE);
        dma_resp_valid  = ~reset & head_entry.valid & (head_entry.owner == OWNER_DMA);
        core_resp_rdata = (core_resp_valid & ~head_entry.is_write) ? mem_rdata : '0;
        dma_resp_rdata  = (dma_resp_valid & ~head_entry.is_write) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dtim_port_arbiter.sv
module tb_dtim_port_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Shared request stimulus for both instances (MEM_LATENCY 1 and 2).
    logic        core_req_valid, core_req_write, dma_req_valid, dma_req_write;
    logic [11:0] core_req_addr, dma_req_addr;
    logic [31:0] core_req_wdata, dma_req_wdata;
    logic [3:0]  core_req_wmask, dma_req_wmask;

    logic        cr1, dr1, cv1, dv1, en1, cr2, dr2, cv2, dv2, en2;
    logic [31:0] cd1, dd1, cd2, dd2, wd1, wd2, rd1, rd2;
    logic [3:0]  we1, we2;
    logic [11:0] ad1, ad2;

    dtim_port_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_ready(cr1), .core_req_write(core_req_write),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_req_wmask(core_req_wmask), .core_resp_valid(cv1), .core_resp_rdata(cd1),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dr1), .dma_req_write(dma_req_write),
        .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
        .dma_req_wmask(dma_req_wmask), .dma_resp_valid(dv1), .dma_resp_rdata(dd1),
        .mem_en(en1), .mem_we(we1), .mem_addr(ad1), .mem_wdata(wd1), .mem_rdata(rd1)
    );

    dtim_port_arbiter #(.MEM_LATENCY(2)) dut2 (
        .clock(clock), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_ready(cr2), .core_req_write(core_req_write),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_req_wmask(core_req_wmask), .core_resp_valid(cv2), .core_resp_rdata(cd2),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dr2), .dma_req_write(dma_req_write),
        .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
        .dma_req_wmask(dma_req_wmask), .dma_resp_valid(dv2), .dma_resp_rdata(dd2),
        .mem_en(en2), .mem_we(we2), .mem_addr(ad2), .mem_wdata(wd2), .mem_rdata(rd2)
    );

    // RAM models, read-first; contents start as 0xC0DE0000 | address.
    logic [31:0] mem1 [4096];
    logic [31:0] mem2 [4096];
    logic [31:0] rd1_q, rd2_q, rd2_qq;
    logic        ram_init_q = 1'b0;

    always @(posedge clock) begin
        if (!ram_init_q) begin
            for (int i = 0; i < 4096; i++) begin
                mem1[i] <= 32'hC0DE0000 | 32'(i);
                mem2[i] <= 32'hC0DE0000 | 32'(i);
            end
            ram_init_q <= 1'b1;
        end else begin
            if (en1) begin
                rd1_q <= mem1[ad1];
                for (int b = 0; b < 4; b++) if (we1[b]) mem1[ad1][8*b +: 8] <= wd1[8*b +: 8];
            end
            if (en2) begin
                rd2_q <= mem2[ad2];
                for (int b = 0; b < 4; b++) if (we2[b]) mem2[ad2][8*b +: 8] <= wd2[8*b +: 8];
            end
        end
        rd2_qq <= rd2_q;
    end
    assign rd1 = rd1_q;
    assign rd2 = rd2_qq;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic cw, input logic [11:0] ca,
                         input logic [31:0] cd, input logic [3:0] cm,
                         input logic dv, input logic dw, input logic [11:0] da,
                         input logic [31:0] dd, input logic [3:0] dm);
        core_req_valid = cv; core_req_write = cw; core_req_addr = ca;
        core_req_wdata = cd; core_req_wmask = cm;
        dma_req_valid  = dv; dma_req_write  = dw; dma_req_addr  = da;
        dma_req_wdata  = dd; dma_req_wmask  = dm;
    endtask

    // Inputs are applied on the falling edge and outputs checked 2 ns later.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " core_ready"}, 32'(cr1), 0);
        chk({tag, " dma_ready"}, 32'(dr1), 0);
        chk({tag, " mem_en"}, 32'(en1), 0);
        chk({tag, " mem_we"}, 32'(we1), 0);
        chk({tag, " core_resp_valid"}, 32'(cv1), 0);
        chk({tag, " core_resp_rdata"}, cd1, 0);
        chk({tag, " dma_resp_valid"}, 32'(dv1), 0);
        chk({tag, " dma_resp_rdata"}, dd1, 0);
    endtask

    typedef struct {
        logic        cv, cw; logic [11:0] ca; logic [31:0] cd; logic [3:0] cm;
        logic        dv, dw; logic [11:0] da; logic [31:0] dd; logic [3:0] dm;
        logic        ecr, edr, een; logic [3:0] ewe; logic [11:0] eaddr; logic [31:0] ewd;
        logic        ecv; logic [31:0] ecd; logic edv; logic [31:0] edd;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Each row: request this cycle; expected handshake/RAM port this cycle, and the
        // response for the previous row's access (MEM_LATENCY = 1).
        vecs[0]  = '{1,1,'h010,'hDEADBEEF,'hF, 0,0,0,0,0, 1,0,1,'hF,'h010,'hDEADBEEF, 0,0,0,0};
        vecs[1]  = '{1,0,'h010,0,0, 0,0,0,0,0, 1,0,1,0,'h010,0, 1,0,0,0};
        vecs[2]  = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 1,'hDEADBEEF,0,0};
        vecs[3]  = '{1,1,'h020,'h11223344,'hF, 0,0,0,0,0, 1,0,1,'hF,'h020,'h11223344, 0,0,0,0};
        vecs[4]  = '{1,1,'h020,'h0000AB00,'h2, 0,0,0,0,0, 1,0,1,'h2,'h020,'h0000AB00, 1,0,0,0};
        vecs[5]  = '{1,0,'h020,0,0, 0,0,0,0,0, 1,0,1,0,'h020,0, 1,0,0,0};
        vecs[6]  = '{0,0,0,0,0, 1,0,'h010,0,0, 0,1,1,0,'h010,0, 1,'h1122AB44,0,0};
        vecs[7]  = '{1,1,'h010,'hFFFFFFFF,0, 0,0,0,0,0, 1,0,1,0,'h010,'hFFFFFFFF, 0,0,1,'hDEADBEEF};
        vecs[8]  = '{0,0,0,0,0, 1,0,'h010,0,0, 0,1,1,0,'h010,0, 1,0,0,0};
        vecs[9]  = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,1,'hDEADBEEF};
        vecs[10] = '{0,0,0,0,0, 1,1,'h030,'h55AA55AA,'hF, 0,1,1,'hF,'h030,'h55AA55AA, 0,0,0,0};
        vecs[11] = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,1,0};
        vecs[12] = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0};

        drive(0,0,0,0,0, 0,0,0,0,0);

        // Reset with requests present: nothing granted, nothing driven.
        step(); reset = 1'b1; drive(1,0,'h010,0,0, 1,0,'h020,0,0); #2;
        chk_all_zero("reset");
        step(); reset = 1'b0; drive(0,0,0,0,0, 0,0,0,0,0); #2;
        chk_all_zero("post_reset");

        // Table: write/read, byte mask, mask-0 no-op write, dma read/write.
        for (int r = 0; r < 13; r++) begin
            step();
            drive(vecs[r].cv, vecs[r].cw, vecs[r].ca, vecs[r].cd, vecs[r].cm,
                  vecs[r].dv, vecs[r].dw, vecs[r].da, vecs[r].dd, vecs[r].dm);
            #2;
            chk($sformatf("row%0d core_ready", r), 32'(cr1), 32'(vecs[r].ecr));
            chk($sformatf("row%0d dma_ready", r), 32'(dr1), 32'(vecs[r].edr));
            chk($sformatf("row%0d mem_en", r), 32'(en1), 32'(vecs[r].een));
            chk($sformatf("row%0d mem_we", r), 32'(we1), 32'(vecs[r].ewe));
            if (vecs[r].een) chk($sformatf("row%0d mem_addr", r), 32'(ad1), 32'(vecs[r].eaddr));
            if (vecs[r].ewe != 0) chk($sformatf("row%0d mem_wdata", r), wd1, vecs[r].ewd);
            chk($sformatf("row%0d core_resp_valid", r), 32'(cv1), 32'(vecs[r].ecv));
            chk($sformatf("row%0d core_resp_rdata", r), cd1, vecs[r].ecd);
            chk($sformatf("row%0d dma_resp_valid", r), 32'(dv1), 32'(vecs[r].edv));
            chk($sformatf("row%0d dma_resp_rdata", r), dd1, vecs[r].edd);
        end

        // DMA alone: granted every cycle, starvation count never builds up.
        for (int j = 0; j < 5; j++) begin
            step(); drive(0,0,0,0,0, 1,0,'h020,0,0); #2;
            chk($sformatf("dma_only%0d dma_ready", j), 32'(dr1), 1);
            chk($sformatf("dma_only%0d core_ready", j), 32'(cr1), 0);
            if (j > 0) chk($sformatf("dma_only%0d dma_rdata", j), dd1, 32'h1122AB44);
        end

        // Both valid: core x4 then dma x1, repeating; responses go to their issuers.
        begin
            logic prev_dma = 1'b1;
            for (int j = 0; j < 10; j++) begin
                logic dg;
                dg = (j == 4) || (j == 9);
                step(); drive(1,0,'h010,0,0, 1,0,'h020,0,0); #2;
                chk($sformatf("both%0d core_ready", j), 32'(cr1), 32'(!dg));
                chk($sformatf("both%0d dma_ready", j), 32'(dr1), 32'(dg));
                chk($sformatf("both%0d core_resp_rdata", j), cd1,
                    prev_dma ? 32'h0 : 32'hDEADBEEF);
                chk($sformatf("both%0d dma_resp_valid", j), 32'(dv1), 32'(prev_dma));
                prev_dma = dg;
            end
        end
        step(); drive(0,0,0,0,0, 0,0,0,0,0); #2;
        chk("both_tail dma_rdata", dd1, 32'h1122AB44);
        chk("both_tail core_resp_valid", 32'(cv1), 0);

        // Reset one cycle after a core read accept, with starve count at 3.
        for (int j = 0; j < 3; j++) begin
            step(); drive(1,0,'h010,0,0, 1,0,'h020,0,0); #2;
            chk($sformatf("pre_rst%0d core_ready", j), 32'(cr1), 1);
        end
        step(); reset = 1'b1; #2;
        chk_all_zero("mid_reset");
        step(); reset = 1'b0; drive(0,0,0,0,0, 0,0,0,0,0); #2;
        chk_all_zero("after_reset");
        for (int j = 0; j < 5; j++) begin
            step(); drive(1,0,'h010,0,0, 1,0,'h020,0,0); #2;
            chk($sformatf("restart%0d dma_ready", j), 32'(dr1), 32'(j == 4));
        end
        for (int j = 0; j < 3; j++) begin
            step(); drive(0,0,0,0,0, 0,0,0,0,0); #2;
        end

        // MEM_LATENCY=2 instance: four back-to-back dma reads of untouched words.
        for (int j = 0; j < 7; j++) begin
            logic exp_v;
            step();
            if (j < 4) drive(0,0,0,0,0, 1,0,12'(j),0,0);
            else       drive(0,0,0,0,0, 0,0,0,0,0);
            #2;
            exp_v = (j >= 2) && (j <= 5);
            if (j < 4) chk($sformatf("lat2_%0d dma_ready", j), 32'(dr2), 1);
            chk($sformatf("lat2_%0d dma_resp_valid", j), 32'(dv2), 32'(exp_v));
            chk($sformatf("lat2_%0d dma_resp_rdata", j), dd2,
                exp_v ? (32'hC0DE0000 | 32'(j - 2)) : 32'h0);
            chk($sformatf("lat2_%0d core_resp_valid", j), 32'(cv2), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
